// File: rtl/cgra_pe_pkg.sv
// Shared constants for the CGRA processing-element datapath blocks.
// Holds the default word width and the demux destination encodings.
package cgra_pe_pkg;

  localparam int DATA_W = 32;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_OUT1 = 2'b00;
  localparam sel_t SEL_OUT2 = 2'b01;
  localparam sel_t SEL_OUT3 = 2'b10;
  localparam sel_t SEL_DROP = 2'b11;

endpackage

// File: rtl/pe_sync_fifo.sv
// Single-clock FIFO with a registered head word and a synchronous active-high reset.
// DEPTH must be a power of two so that the pointers wrap naturally.
module pe_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // Head reads as zero when empty so idle outputs never show stale words.
  assign head_o = empty_o ? '0 : mem_q[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (doPush) mem_q[wrPtr_q] <= din_i;
    end
  end

endmodule

// File: rtl/demux1_3_buf.sv
// Buffered 1-to-3 demultiplexer: routes each accepted word to one of three FIFOs or discards it.
// Optional macro DEMUX_DROP_CNT_EN adds a saturating 16-bit count of discarded words.
module demux1_3_buf
  import cgra_pe_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data_1,
  output logic [WIDTH-1:0] out_data_2,
  output logic [WIDTH-1:0] out_data_3,
  output logic             out_valid_1,
  output logic             out_valid_2,
  output logic             out_valid_3,
  input  logic             out_ready_1,
  input  logic             out_ready_2,
  input  logic             out_ready_3
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  logic [2:0]       push, pop, full, empty, outReady;
  logic [WIDTH-1:0] head [3];
  logic             selFull, accept;

  assign outReady = {out_ready_3, out_ready_2, out_ready_1};

  // Readiness depends only on the selected FIFO's registered fullness, never on out_ready_n.
  always_comb begin
    selFull = 1'b0;
    case (in_sel)
      SEL_OUT1: selFull = full[0];
      SEL_OUT2: selFull = full[1];
      SEL_OUT3: selFull = full[2];
      SEL_DROP: selFull = 1'b0;
      default:  selFull = 1'b0;
    endcase
    in_ready = !rst && !selFull;
  end

  assign accept  = in_valid && in_ready;
  assign push[0] = accept && (in_sel == SEL_OUT1);
  assign push[1] = accept && (in_sel == SEL_OUT2);
  assign push[2] = accept && (in_sel == SEL_OUT3);

  for (genvar n = 0; n < 3; n++) begin : gFifo
    assign pop[n] = !empty[n] && outReady[n];

    pe_sync_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) uFifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push[n]),
      .pop_i  (pop[n]),
      .din_i  (in_data),
      .full_o (full[n]),
      .empty_o(empty[n]),
      .head_o (head[n])
    );
  end

  assign out_valid_1 = !empty[0];
  assign out_valid_2 = !empty[1];
  assign out_valid_3 = !empty[2];
  assign out_data_1  = head[0];
  assign out_data_2  = head[1];
  assign out_data_3  = head[2];

`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] dropCnt_q, dropCnt_d;

  always_comb begin
    dropCnt_d = dropCnt_q;
    if (accept && (in_sel == SEL_DROP) && (dropCnt_q != 16'hFFFF))
      dropCnt_d = dropCnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) dropCnt_q <= '0;
    else     dropCnt_q <= dropCnt_d;
  end

  assign drop_cnt = dropCnt_q;
`endif

endmodule

// File: tb/tb_demux1_3_buf.sv
// Directed, table-driven bench for demux1_3_buf with hand-computed expectations.
// Also exercises the drop counter when built with DEMUX_DROP_CNT_EN.
module tb_demux1_3_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inData = '0;
  logic [1:0]  inSel = 2'b00;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] outData1, outData2, outData3;
  logic        outValid1, outValid2, outValid3;
  logic        outReady1 = 1'b0, outReady2 = 1'b0, outReady3 = 1'b0;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] dropCnt;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  demux1_3_buf #(.WIDTH(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (inData),
    .in_sel     (inSel),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .out_data_1 (outData1),
    .out_data_2 (outData2),
    .out_data_3 (outData3),
    .out_valid_1(outValid1),
    .out_valid_2(outValid2),
    .out_valid_3(outValid3),
    .out_ready_1(outReady1),
    .out_ready_2(outReady2),
    .out_ready_3(outReady3)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt   (dropCnt)
`endif
  );

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [31:0] d;
    logic [2:0]  rdy;
    logic        expReady;
    logic [2:0]  expValid;
    logic [31:0] expD1;
    logic [31:0] expD2;
    logic [31:0] expD3;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge, away from the sampling edge.
  task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic [31:0] d,
                               input logic [2:0] rdy);
    @(negedge clk);
    inValid   = v;
    inSel     = sel;
    inData    = d;
    outReady1 = rdy[0];
    outReady2 = rdy[1];
    outReady3 = rdy[2];
  endtask

  initial begin
    // Rows: v sel data rdy{3,2,1} | in_ready, valid{3,2,1}, data1..3 after the edge.
    vecs[0]  = '{1'b1, 2'b01, 32'hA5A5_0001, 3'b000, 1'b1, 3'b010, 32'h0, 32'hA5A5_0001, 32'h0};
    vecs[1]  = '{1'b0, 2'b00, 32'h0,         3'b010, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0};
    vecs[2]  = '{1'b1, 2'b00, 32'h11,        3'b000, 1'b1, 3'b001, 32'h11, 32'h0, 32'h0};
    vecs[3]  = '{1'b1, 2'b00, 32'h12,        3'b000, 1'b1, 3'b001, 32'h11, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 2'b00, 32'h13,        3'b000, 1'b0, 3'b001, 32'h11, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 2'b10, 32'h31,        3'b000, 1'b1, 3'b101, 32'h11, 32'h0, 32'h31};
    vecs[6]  = '{1'b0, 2'b00, 32'h0,         3'b100, 1'b0, 3'b001, 32'h11, 32'h0, 32'h0};
    vecs[7]  = '{1'b1, 2'b00, 32'h14,        3'b001, 1'b0, 3'b001, 32'h12, 32'h0, 32'h0};
    vecs[8]  = '{1'b1, 2'b00, 32'h15,        3'b001, 1'b1, 3'b001, 32'h15, 32'h0, 32'h0};
    vecs[9]  = '{1'b1, 2'b11, 32'hDEAD_0001, 3'b000, 1'b1, 3'b001, 32'h15, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 2'b11, 32'hDEAD_0002, 3'b000, 1'b1, 3'b001, 32'h15, 32'h0, 32'h0};
    vecs[11] = '{1'b1, 2'b11, 32'hDEAD_0003, 3'b000, 1'b1, 3'b001, 32'h15, 32'h0, 32'h0};
    vecs[12] = '{1'b1, 2'b11, 32'hDEAD_0004, 3'b000, 1'b1, 3'b001, 32'h15, 32'h0, 32'h0};
    vecs[13] = '{1'b1, 2'b11, 32'hDEAD_0005, 3'b000, 1'b1, 3'b001, 32'h15, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 2'b00, 32'h0,         3'b001, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0};

    // Reset held three cycles with a word offered: nothing accepted, outputs clear.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rst = 1'b1; inValid = 1'b1; inSel = 2'b00; inData = 32'hFFFF_FFFF;
      #1 checkOutput($sformatf("reset%0d in_ready", c), 32'(inReady), 32'h0);
      @(posedge clk); #1;
      checkOutput($sformatf("reset%0d valid", c), 32'({outValid3, outValid2, outValid1}), 32'h0);
      checkOutput($sformatf("reset%0d data1", c), outData1, 32'h0);
      checkOutput($sformatf("reset%0d data2", c), outData2, 32'h0);
      checkOutput($sformatf("reset%0d data3", c), outData3, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("post-reset in_ready", 32'(inReady), 32'h1);
    inValid = 1'b0;
`ifdef DEMUX_DROP_CNT_EN
    checkOutput("reset drop_cnt", 32'(dropCnt), 32'h0);
`endif

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].rdy);
      #1 checkOutput($sformatf("vec%0d in_ready", i), 32'(inReady), 32'(vecs[i].expReady));
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d valid", i), 32'({outValid3, outValid2, outValid1}),
                  32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d data1", i), outData1, vecs[i].expD1);
      checkOutput($sformatf("vec%0d data2", i), outData2, vecs[i].expD2);
      checkOutput($sformatf("vec%0d data3", i), outData3, vecs[i].expD3);
    end
`ifdef DEMUX_DROP_CNT_EN
    checkOutput("drop_cnt after discards", 32'(dropCnt), 32'd5);
`endif

    // Back-to-back stream on channel 1 with the consumer always ready.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 2'b00, 32'(k), 3'b001);
      #1 checkOutput($sformatf("stream%0d in_ready", k), 32'(inReady), 32'h1);
      @(posedge clk); #1;
      checkOutput($sformatf("stream%0d valid1", k), 32'(outValid1), 32'h1);
      checkOutput($sformatf("stream%0d data1", k), outData1, 32'(k));
    end
    applyStimulus(1'b0, 2'b00, 32'h0, 3'b001);
    @(posedge clk); #1;
    checkOutput("stream drained valid1", 32'(outValid1), 32'h0);

    // Reset mid-stream drops FIFO 3 contents; a fresh word is then the only one seen.
    applyStimulus(1'b1, 2'b10, 32'h301, 3'b000);
    applyStimulus(1'b1, 2'b10, 32'h302, 3'b000);
    @(posedge clk); #1;
    checkOutput("midrst pre valid3", 32'(outValid3), 32'h1);
    checkOutput("midrst pre data3", outData3, 32'h301);
    applyStimulus(1'b1, 2'b10, 32'h303, 3'b100);
    rst = 1'b1;
    #1 checkOutput("midrst in_ready", 32'(inReady), 32'h0);
    @(posedge clk); #1;
    checkOutput("midrst valid3", 32'(outValid3), 32'h0);
    checkOutput("midrst data3", outData3, 32'h0);
`ifdef DEMUX_DROP_CNT_EN
    checkOutput("midrst drop_cnt", 32'(dropCnt), 32'h0);
`endif
    applyStimulus(1'b1, 2'b10, 32'h777, 3'b000);
    rst = 1'b0;
    #1 checkOutput("after midrst in_ready", 32'(inReady), 32'h1);
    @(posedge clk); #1;
    checkOutput("after midrst valid3", 32'(outValid3), 32'h1);
    checkOutput("after midrst data3", outData3, 32'h777);
    applyStimulus(1'b0, 2'b00, 32'h0, 3'b100);
    @(posedge clk); #1;
    checkOutput("after midrst drained valid3", 32'(outValid3), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
